vcr_regfile: RTL
================

// Module: vcr_regfile
// PURPOSE
//  Parametrised Vendor Command/Request endpoint: EZ-USB drives 8-bit address/data via EP0 handler; FPGA decodes.
//  Provides N multi-byte config registers (atomic commit), command strobes, coherent status snapshot, timed reset pulse.
//  Sits between EZ-USB VCR pins and application/IO control logic, all in IFCLK domain.
// PARAMETERS
//  N_REGS        4      config registers, addresses 0xC0+k (k<N_REGS, N_REGS<=16)
//  REG_BYTES     2      bytes per config register (1..4); cfg width = 8*REG_BYTES
//  CFG_INIT      0      reset value of every config register
//  N_STROBES     4      command strobes, addresses 0x90+k (k<N_STROBES, <=16)
//  N_STATUS      6      status bytes returned by GET_STATUS (0x84)
//  RESET_CYCLES  16     reset_out pulse length in IFCLK cycles (>=1)
//  BITSTREAM_TYPE 16'h1 returned by GET_ID_DATA (0xA1), LSB first
//  ECHO_DEPTH    4      echo buffer bytes (power of 2), only with VCR_ECHO_EN
// PORTS
//  IFCLK         in   1                  sole clock
//  RESET         in   1                  asynchronous, active-high
//  CS            in   1                  chip select; enables ignored when low
//  vcr_in        in   8                  VCR address/data from EZ-USB
//  clk_vcr_addr  in   1                  async; rising edge = address phase
//  clk_vcr_data  in   1                  async; rising edge = data phase (write byte / advance read)
//  FPGA_ID       in   3                  returned by 0x8A as {5'b0,FPGA_ID}
//  status_in     in   8*N_STATUS         status bytes, byte i = [8i+7:8i]
//  vcr_out       out  8                  read data, combinational from addr/ptr/registers
//  cfg_out       out  8*REG_BYTES*N_REGS committed config registers
//  cfg_update    out  N_REGS             1-cycle pulse on commit of register k
//  cmd_strobe    out  N_STROBES          1-cycle pulse per strobe command
//  reset_out     out  1                  timed reset pulse to application
// BEHAVIOUR
//  Sync: each async input -> 2-flop sync + rising-edge detect -> 1-cycle enable; edge-to-enable 3 IFCLK.
//   Host guarantees >=4 IFCLK between edges; closer edges may merge (unsupported).
//  Reset: vcr_addr=0, ptr=0, cfg_out=CFG_INIT, shadow=0, snapshot=0, cfg_update=0, cmd_strobe=0, reset_out=0, echo=0.
//  Address phase (CS & addr_en): vcr_addr<=vcr_in; ptr<=0; snapshot<=status_in (coherent multi-byte read);
//   0x90+k -> cmd_strobe[k] high next cycle for exactly 1 cycle; 0x8B -> reset_out high, counter<=RESET_CYCLES-1.
//   Unknown addresses: latched, no side effect, reads 0.
//  Data phase (CS & data_en): ptr<=ptr+1, saturates at 8'hFF.
//   0xC0+k write: shadow[ptr]<=vcr_in if ptr<REG_BYTES; on ptr==REG_BYTES-1 commit shadow (incl. this byte) to
//   cfg_out[k] next cycle + cfg_update[k] pulse. Bytes beyond REG_BYTES ignored. Partial write: no commit, cfg_out kept;
//   new address phase discards shadow.
//  Reads (vcr_out, byte at current ptr, 0 when out of range): 0x84 snapshot[ptr<N_STATUS]; 0xC0+k cfg_out[k] byte ptr;
//   0xA1 BITSTREAM_TYPE byte ptr<2; 0x8A FPGA_ID; 0x88 echo (see CONFIGURATION); all else 8'h00.
//  addr_en & data_en same cycle: address phase wins, data phase dropped.
//  reset_out: counts down to 0 then deasserts; length exactly RESET_CYCLES; new 0x8B while active restarts count.
//   reset_out does not reset this block; RESET aborts pulse immediately.
//  CS low: pending enables discarded; counters and strobes still complete.
// CONFIGURATION
//  VCR_ECHO_EN defined: 0x88 data phase writes echo[ptr mod ECHO_DEPTH]; read returns echo[ptr mod ECHO_DEPTH]^8'h5A.
//  VCR_ECHO_EN undefined: no echo storage; 0x88 writes ignored, reads 8'h00.
// STRUCTURE
//  vcr_pkg: address localparams (0x84,0x88,0x8A,0x8B,0x90 base,0xA1,0xC0 base), ECHO_XOR=8'h5A, ptr width 8.
//  Sub-module vcr_edge_sync (2-flop sync + edge detect, async reset), instantiated twice.
// TESTING
//  1 addr 0xC1, data 0x34,0x12 (REG_BYTES=2) -> cfg_out[1]=16'h1234, one cfg_update[1] pulse; readback 0x34,0x12.
//  2 addr 0xC0, data 0xAA only, then addr 0x84 -> cfg_out[0] stays CFG_INIT, no cfg_update.
//  3 status_in changes between data phases of 0x84 -> all bytes read match value at address phase.
//  4 addr 0x8B, repeat after 5 cycles -> reset_out high 5+RESET_CYCLES cycles; RESET mid-pulse -> 0 at once.
//  5 addr 0x92 -> cmd_strobe[2] high 1 cycle; CS=0 with edges -> no strobe, no register change.
//  6 VCR_ECHO_EN: write 0x01..0x04 to 0x88, re-address -> reads 0x5B,0x58,0x59,0x5E; without macro -> 0x00.

Source files
------------

// File: rtl/vcr_pkg.sv
// Shared constants for the vendor command/request register endpoint.
// Holds the decoded command addresses, the echo scramble value and the pointer width.
package vcr_pkg;

    localparam int PTR_W = 8;

    localparam logic [7:0] ADDR_STATUS  = 8'h84;
    localparam logic [7:0] ADDR_ECHO    = 8'h88;
    localparam logic [7:0] ADDR_FPGA_ID = 8'h8A;
    localparam logic [7:0] ADDR_RESET   = 8'h8B;
    localparam logic [7:0] ADDR_STROBE  = 8'h90;
    localparam logic [7:0] ADDR_ID_DATA = 8'hA1;
    localparam logic [7:0] ADDR_CFG     = 8'hC0;

    localparam logic [7:0] ECHO_XOR     = 8'h5A;

    // Address of the k-th entry of a block that starts at base.
    function automatic logic [7:0] win_addr(input logic [7:0] base, input int k);
        return base + 8'(k);
    endfunction

endpackage

// File: rtl/vcr_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous strobe pin.
// Produces a one-cycle enable; the pin edge becomes an action on the third IFCLK edge.
module vcr_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    // Shift the pin through the synchroniser and a history stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vcr_regfile.sv
// Vendor command/request register endpoint in the IFCLK domain.
// Optional echo buffer at 0x88 is built only when VCR_ECHO_EN is defined.
module vcr_regfile
    import vcr_pkg::*;
#(
    parameter int          N_REGS         = 4,
    parameter int          REG_BYTES      = 2,
    parameter logic [31:0] CFG_INIT       = 32'h0,
    parameter int          N_STROBES      = 4,
    parameter int          N_STATUS       = 6,
    parameter int          RESET_CYCLES   = 16,
    parameter logic [15:0] BITSTREAM_TYPE = 16'h0001,
    parameter int          ECHO_DEPTH     = 4
) (
    input  logic                          IFCLK,
    input  logic                          RESET,
    input  logic                          CS,
    input  logic [7:0]                    vcr_in,
    input  logic                          clk_vcr_addr,
    input  logic                          clk_vcr_data,
    input  logic [2:0]                    FPGA_ID,
    input  logic [8*N_STATUS-1:0]         status_in,
    output logic [7:0]                    vcr_out,
    output logic [8*REG_BYTES*N_REGS-1:0] cfg_out,
    output logic [N_REGS-1:0]             cfg_update,
    output logic [N_STROBES-1:0]          cmd_strobe,
    output logic                          reset_out
);

    localparam int CFG_W = 8 * REG_BYTES;
    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic addr_en;
    logic data_en;
    logic addr_fire;
    logic data_fire;

    logic [7:0]                addr_q,    addr_d;
    logic [PTR_W-1:0]          ptr_q,     ptr_d;
    logic [8*N_STATUS-1:0]     snap_q,    snap_d;
    logic [CFG_W-1:0]          shadow_q,  shadow_d;
    logic [CFG_W*N_REGS-1:0]   cfg_q,     cfg_d;
    logic [N_REGS-1:0]         upd_q,     upd_d;
    logic [N_STROBES-1:0]      stb_q,     stb_d;
    logic                      rst_out_q, rst_out_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [7:0]                echo_rd;

    vcr_edge_sync u_addr_sync (
        .clk_i   (IFCLK),
        .rst_i   (RESET),
        .async_i (clk_vcr_addr),
        .rise_o  (addr_en)
    );

    vcr_edge_sync u_data_sync (
        .clk_i   (IFCLK),
        .rst_i   (RESET),
        .async_i (clk_vcr_data),
        .rise_o  (data_en)
    );

    assign addr_fire = CS & addr_en;
    assign data_fire = CS & data_en & ~addr_en;

    // Decode address/data phases into next-state for all command state.
    always_comb begin
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        cfg_d     = cfg_q;
        upd_d     = '0;
        stb_d     = '0;
        rst_out_d = rst_out_q;
        cnt_d     = cnt_q;

        if (rst_out_q) begin
            if (cnt_q == '0) begin
                rst_out_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (addr_fire) begin
            addr_d   = vcr_in;
            ptr_d    = '0;
            snap_d   = status_in;
            shadow_d = '0;
            for (int k = 0; k < N_STROBES; k++) begin
                if (vcr_in == win_addr(ADDR_STROBE, k)) begin
                    stb_d[k] = 1'b1;
                end
            end
            if (vcr_in == ADDR_RESET) begin
                rst_out_d = 1'b1;
                cnt_d     = CNT_W'(RESET_CYCLES - 1);
            end
        end else if (data_fire) begin
            if (ptr_q != 8'hFF) begin
                ptr_d = ptr_q + 1'b1;
            end
            for (int k = 0; k < N_REGS; k++) begin
                if (addr_q == win_addr(ADDR_CFG, k)) begin
                    for (int b = 0; b < REG_BYTES; b++) begin
                        if (ptr_q == 8'(b)) begin
                            shadow_d[b*8 +: 8] = vcr_in;
                        end
                    end
                    if (ptr_q == 8'(REG_BYTES - 1)) begin
                        cfg_d[k*CFG_W +: CFG_W] = shadow_d;
                        upd_d[k]                = 1'b1;
                    end
                end
            end
        end
    end

    // Command state registers; RESET also aborts any reset_out pulse.
    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            addr_q    <= '0;
            ptr_q     <= '0;
            snap_q    <= '0;
            shadow_q  <= '0;
            cfg_q     <= {N_REGS{CFG_INIT[CFG_W-1:0]}};
            upd_q     <= '0;
            stb_q     <= '0;
            rst_out_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
            cfg_q     <= cfg_d;
            upd_q     <= upd_d;
            stb_q     <= stb_d;
            rst_out_q <= rst_out_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef VCR_ECHO_EN
    localparam int EW = $clog2(ECHO_DEPTH);

    logic [7:0]    echo_q [ECHO_DEPTH];
    logic [EW-1:0] echo_idx;

    assign echo_idx = ptr_q[EW-1:0];

    // Echo buffer: data phases at 0x88 store the byte at ptr modulo depth.
    always_ff @(posedge IFCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ECHO_DEPTH; i++) begin
                echo_q[i] <= 8'h00;
            end
        end else if (data_fire && addr_q == ADDR_ECHO) begin
            echo_q[echo_idx] <= vcr_in;
        end
    end

    assign echo_rd = echo_q[echo_idx] ^ ECHO_XOR;
`else
    assign echo_rd = 8'h00;
`endif

    // Read mux: byte at the current pointer, zero when out of range.
    always_comb begin
        vcr_out = 8'h00;
        if (addr_q == ADDR_STATUS) begin
            for (int i = 0; i < N_STATUS; i++) begin
                if (ptr_q == 8'(i)) begin
                    vcr_out = snap_q[i*8 +: 8];
                end
            end
        end
        for (int k = 0; k < N_REGS; k++) begin
            for (int b = 0; b < REG_BYTES; b++) begin
                if (addr_q == win_addr(ADDR_CFG, k) && ptr_q == 8'(b)) begin
                    vcr_out = cfg_q[(k*REG_BYTES + b)*8 +: 8];
                end
            end
        end
        if (addr_q == ADDR_ID_DATA) begin
            if (ptr_q == 8'd0) begin
                vcr_out = BITSTREAM_TYPE[7:0];
            end else if (ptr_q == 8'd1) begin
                vcr_out = BITSTREAM_TYPE[15:8];
            end
        end
        if (addr_q == ADDR_FPGA_ID) begin
            vcr_out = {5'b00000, FPGA_ID};
        end
        if (addr_q == ADDR_ECHO) begin
            vcr_out = echo_rd;
        end
    end

    assign cfg_out    = cfg_q;
    assign cfg_update = upd_q;
    assign cmd_strobe = stb_q;
    assign reset_out  = rst_out_q;

endmodule
